// File: rtl/multiport_memory.sv
// ============================================================================
// Module   : multiport_memory
// Purpose  : One-write / NUM_READ-read RAM with lane enables, wait states,
//            req/busy/valid handshakes and a hardware clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiport_memory #(
    parameter int WORD_SIZE    = 8,
    parameter int LANE_SIZE    = 8,
    parameter logic [WORD_SIZE-1:0] WORD_INIT = '0,
    parameter int ADDRESS_SIZE = 4,
    parameter int MEMORY_QTY   = 16,
    parameter int NUM_READ     = 2,
    parameter int WAIT_SIZE    = 2,
    parameter int READ_WAIT    = 0,
    parameter int WRITE_WAIT   = 0,
    parameter int WRITE_FIRST  = 0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             clear,
    output logic                             init_done,
    input  logic                             w_req,
    input  logic [ADDRESS_SIZE-1:0]          w_addr,
    input  logic [WORD_SIZE-1:0]             w_data,
    input  logic [WORD_SIZE/LANE_SIZE-1:0]   w_lane,
    output logic                             w_busy,
    output logic                             w_done,
    input  logic [NUM_READ-1:0]              r_req,
    input  logic [NUM_READ*ADDRESS_SIZE-1:0] r_addr,
    output logic [NUM_READ*WORD_SIZE-1:0]    r_data,
    output logic [NUM_READ-1:0]              r_busy,
    output logic [NUM_READ-1:0]              r_valid,
    output logic                             addr_err
);

    localparam int c_LANES = WORD_SIZE / LANE_SIZE;
    localparam int c_IW    = (MEMORY_QTY > 1) ? $clog2(MEMORY_QTY) : 1;
    localparam logic [c_IW-1:0]      c_LAST  = c_IW'(MEMORY_QTY - 1);
    localparam logic [WAIT_SIZE-1:0] c_WWAIT = WAIT_SIZE'(WRITE_WAIT);
    localparam logic [WAIT_SIZE-1:0] c_RWAIT = WAIT_SIZE'(READ_WAIT);

    typedef enum logic [1:0] {WS_INIT = 2'd0, WS_IDLE = 2'd1, WS_WWAIT = 2'd2} wstate_t;
    typedef enum logic [1:0] {RS_INIT = 2'd0, RS_IDLE = 2'd1, RS_WAIT = 2'd2} rstate_t;

    logic [WORD_SIZE-1:0] r_mem [MEMORY_QTY];
    wstate_t              r_wstate;
    logic [c_IW-1:0]      r_idx;
    logic [WAIT_SIZE-1:0] r_wcnt;

    logic                 w_clear_take;
    logic                 w_wr_acc;
    logic                 w_wr_inrange;
    logic                 w_sweep_last;
    logic                 w_rd_err;
    logic [NUM_READ-1:0]  w_rerr;
    logic [NUM_READ-1:0]  w_rbusy;
    logic [c_IW-1:0]      w_widx;
    logic [WORD_SIZE-1:0] w_old;
    logic [WORD_SIZE-1:0] w_merged;
    logic                 w_mem_we;
    logic [c_IW-1:0]      w_mem_addr;
    logic [WORD_SIZE-1:0] w_mem_wdata;

    assign w_clear_take = clear & init_done & ~w_busy & ~(|w_rbusy);
    assign w_wr_acc     = w_req & ~w_busy & ~w_clear_take;
    assign w_wr_inrange = 32'(w_addr) < MEMORY_QTY;
    assign w_sweep_last = (r_wstate == WS_INIT) && (r_idx == c_LAST);
    assign w_rd_err     = |w_rerr;
    assign w_widx       = w_addr[c_IW-1:0];
    assign w_old        = w_wr_inrange ? r_mem[w_widx] : '0;

    // Disabled lanes keep the bits already stored at the write address.
    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < c_LANES; i++) begin
            if (w_lane[i]) begin
                w_merged[i*LANE_SIZE +: LANE_SIZE] = w_data[i*LANE_SIZE +: LANE_SIZE];
            end
        end
    end

    assign w_mem_we    = (r_wstate == WS_INIT) | (w_wr_acc & w_wr_inrange);
    assign w_mem_addr  = (r_wstate == WS_INIT) ? r_idx : w_widx;
    assign w_mem_wdata = (r_wstate == WS_INIT) ? WORD_INIT : w_merged;

    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Write channel and clear sweep share one FSM; the sweep owns the write port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wstate  <= WS_INIT;
            r_idx     <= '0;
            r_wcnt    <= '0;
            init_done <= 1'b0;
            w_busy    <= 1'b1;
            w_done    <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            w_done <= 1'b0;
            if (w_rd_err | (w_wr_acc & ~w_wr_inrange)) begin
                addr_err <= 1'b1;
            end
            case (r_wstate)
                WS_INIT: begin
                    r_idx <= r_idx + 1'b1;
                    if (w_sweep_last) begin
                        r_wstate  <= WS_IDLE;
                        r_idx     <= '0;
                        init_done <= 1'b1;
                        w_busy    <= 1'b0;
                    end
                end
                WS_IDLE: begin
                    if (w_clear_take) begin
                        r_wstate  <= WS_INIT;
                        r_idx     <= '0;
                        init_done <= 1'b0;
                        w_busy    <= 1'b1;
                        addr_err  <= 1'b0;
                    end else if (w_wr_acc) begin
                        r_wstate <= WS_WWAIT;
                        r_wcnt   <= c_WWAIT;
                        w_busy   <= 1'b1;
                    end
                end
                WS_WWAIT: begin
                    if (r_wcnt == '0) begin
                        r_wstate <= WS_IDLE;
                        w_done   <= 1'b1;
                        w_busy   <= 1'b0;
                    end else begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end
                end
                default: r_wstate <= WS_INIT;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_READ; c++) begin : g_read
        rstate_t                 r_rstate;
        logic [WAIT_SIZE-1:0]    r_rcnt;
        logic [WORD_SIZE-1:0]    r_rword;
        logic                    r_rbusy;
        logic                    r_rvalid;
        logic [ADDRESS_SIZE-1:0] w_raddr;
        logic                    w_rin;
        logic                    w_racc;
        logic                    w_hit;
        logic [WORD_SIZE-1:0]    w_rword;

        assign w_raddr = r_addr[c*ADDRESS_SIZE +: ADDRESS_SIZE];
        assign w_rin   = 32'(w_raddr) < MEMORY_QTY;
        assign w_racc  = r_req[c] & ~r_rbusy & ~w_clear_take;
        // Same-edge write hit forwards the lane-merged word in write-first mode.
        assign w_hit   = (WRITE_FIRST != 0) && w_wr_acc && w_wr_inrange && (w_addr == w_raddr);
        assign w_rword = !w_rin ? '0 : (w_hit ? w_merged : r_mem[w_raddr[c_IW-1:0]]);

        assign w_rbusy[c] = r_rbusy;
        assign w_rerr[c]  = w_racc & ~w_rin;
        assign r_busy[c]  = r_rbusy;
        assign r_valid[c] = r_rvalid;
        assign r_data[c*WORD_SIZE +: WORD_SIZE] = r_rword;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_rstate <= RS_INIT;
                r_rcnt   <= '0;
                r_rword  <= '0;
                r_rbusy  <= 1'b1;
                r_rvalid <= 1'b0;
            end else begin
                r_rvalid <= 1'b0;
                case (r_rstate)
                    RS_INIT: begin
                        if (w_sweep_last) begin
                            r_rstate <= RS_IDLE;
                            r_rbusy  <= 1'b0;
                        end
                    end
                    RS_IDLE: begin
                        if (w_clear_take) begin
                            r_rstate <= RS_INIT;
                            r_rbusy  <= 1'b1;
                        end else if (w_racc) begin
                            r_rstate <= RS_WAIT;
                            r_rword  <= w_rword;
                            r_rcnt   <= c_RWAIT;
                            r_rbusy  <= 1'b1;
                        end
                    end
                    RS_WAIT: begin
                        if (r_rcnt == '0) begin
                            r_rstate <= RS_IDLE;
                            r_rvalid <= 1'b1;
                            r_rbusy  <= 1'b0;
                        end else begin
                            r_rcnt <= r_rcnt - 1'b1;
                        end
                    end
                    default: r_rstate <= RS_INIT;
                endcase
            end
        end
    end

endmodule

`default_nettype wire
